// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the stage-4 data memory arbiter: word, response owner and request bundle.
package data_memory_arbiter_pkg;

   typedef logic [31:0] word;

   localparam int unsigned STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_PIPE = 2'd1,
      OWN_DBG  = 2'd2
   } arb_owner_t;

   typedef struct packed {
      logic       write;
      word        addr;
      logic [3:0] write_to;
      word        wdata;
   } mem_req_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundles the pipeline, debug and memory-side signals of the data memory arbiter.
interface data_memory_arbiter_if;
   import data_memory_arbiter_pkg::*;

   logic       pipe_req;
   logic       pipe_write;
   word        pipe_addr;
   logic [3:0] pipe_write_to;
   word        pipe_wdata;
   logic       pipe_stall;
   logic       pipe_rvalid;
   word        pipe_rdata;

   logic       dbg_req;
   logic       dbg_write;
   word        dbg_addr;
   logic [3:0] dbg_write_to;
   word        dbg_wdata;
   logic       dbg_gnt;
   logic       dbg_rvalid;
   word        dbg_rdata;

   logic       mem_write;
   word        mem_addr;
   logic [3:0] mem_write_to;
   word        mem_wdata;
   word        mem_read_value;

   // Arbiter side.
   modport slave (
      input  pipe_req, pipe_write, pipe_addr, pipe_write_to, pipe_wdata,
      output pipe_stall, pipe_rvalid, pipe_rdata,
      input  dbg_req, dbg_write, dbg_addr, dbg_write_to, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_write, mem_addr, mem_write_to, mem_wdata,
      input  mem_read_value
   );

   // Requester / memory side.
   modport master (
      output pipe_req, pipe_write, pipe_addr, pipe_write_to, pipe_wdata,
      input  pipe_stall, pipe_rvalid, pipe_rdata,
      output dbg_req, dbg_write, dbg_addr, dbg_write_to, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_write, mem_addr, mem_write_to, mem_wdata,
      output mem_read_value
   );

endinterface

// File: rtl/data_memory_starve_counter.sv
// Saturating count of pipeline wins over a waiting debug request; flags when debug must go next.
module data_memory_starve_counter
   import data_memory_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam logic [STARVE_CNT_W-1:0] Limit = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] starve_cnt_d, starve_cnt_q;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (clr_i) begin
         starve_cnt_d = '0;
      end else if (inc_i && (starve_cnt_q != Limit)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign at_limit_o = (starve_cnt_q == Limit);

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the stage-4 data memory port between the pipeline (priority) and a debug requester,
// and routes the registered read data back to whichever side issued the read.
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   data_memory_arbiter_if.slave  bus
);

   mem_req_t   pipe_r, dbg_r, win_r;
   logic       pipe_granted, dbg_granted, at_limit;
   arb_owner_t rsp_owner_d, rsp_owner_q;

   assign pipe_r = '{write: bus.pipe_write, addr: bus.pipe_addr,
                     write_to: bus.pipe_write_to, wdata: bus.pipe_wdata};
   assign dbg_r  = '{write: bus.dbg_write, addr: bus.dbg_addr,
                     write_to: bus.dbg_write_to, wdata: bus.dbg_wdata};

   data_memory_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_counter (
      .clock      (clock),
      .reset      (reset),
      .inc_i      (pipe_granted & bus.dbg_req),
      .clr_i      (dbg_granted | ~bus.dbg_req),
      .at_limit_o (at_limit)
   );

   always_comb begin
      dbg_granted  = bus.dbg_req & (~bus.pipe_req | at_limit);
      pipe_granted = bus.pipe_req & ~dbg_granted;

      win_r = '0;
      if (dbg_granted) begin
         win_r = dbg_r;
      end else if (pipe_granted) begin
         win_r = pipe_r;
      end

      // Only reads own the next-cycle response slot.
      rsp_owner_d = OWN_NONE;
      if (dbg_granted && !dbg_r.write) begin
         rsp_owner_d = OWN_DBG;
      end else if (pipe_granted && !pipe_r.write) begin
         rsp_owner_d = OWN_PIPE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rsp_owner_q <= OWN_NONE;
      end else begin
         rsp_owner_q <= rsp_owner_d;
      end
   end

   always_comb begin
      bus.mem_write    = win_r.write;
      bus.mem_addr     = win_r.addr;
      bus.mem_write_to = win_r.write_to;
      bus.mem_wdata    = win_r.wdata;

      bus.pipe_stall   = bus.pipe_req & ~pipe_granted;
      bus.dbg_gnt      = dbg_granted;

      bus.pipe_rvalid  = (rsp_owner_q == OWN_PIPE);
      bus.dbg_rvalid   = (rsp_owner_q == OWN_DBG);
      bus.pipe_rdata   = (rsp_owner_q == OWN_PIPE) ? bus.mem_read_value : '0;
      bus.dbg_rdata    = (rsp_owner_q == OWN_DBG)  ? bus.mem_read_value : '0;
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: vector table plus response scoreboard,
// with a write-first, 1-cycle-latency memory model behind the arbiter.
module tb_data_memory_arbiter;
   import data_memory_arbiter_pkg::*;

   typedef struct packed {
      logic       p_req;
      logic       p_wr;
      word        p_addr;
      logic [3:0] p_wt;
      word        p_wd;
      logic       d_req;
      logic       d_wr;
      word        d_addr;
      logic [3:0] d_wt;
      word        d_wd;
      logic       e_stall;
      logic       e_gnt;
      logic       e_mw;
      word        e_maddr;
      logic [3:0] e_mwt;
      word        e_mwd;
      logic [1:0] e_rsp;   // 0 none, 1 pipe, 2 debug
      word        e_rdata;
   } vec_t;

   typedef struct packed {
      logic [1:0] owner;
      word        data;
   } rsp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   failed = 0;

   vec_t vecs[$];
   rsp_t rsp_q[$];

   always #5 clock = ~clock;

   data_memory_arbiter_if bus ();

   data_memory_arbiter #(
      .STARVE_LIMIT (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Write-first memory: a same-edge write is visible in the returned read data.
   word mem_model [256];
   always @(posedge clock) begin : mem_proc
      word cur;
      cur = mem_model[bus.mem_addr[9:2]];
      if (bus.mem_write) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_write_to[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
         end
         mem_model[bus.mem_addr[9:2]] = cur;
      end
      bus.mem_read_value <= cur;
   end

   task automatic chk(input string name, input word act, input word exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t v(
      input logic p_req, input logic p_wr, input word p_addr, input logic [3:0] p_wt,
      input word p_wd, input logic d_req, input logic d_wr, input word d_addr,
      input logic [3:0] d_wt, input word d_wd, input logic e_stall, input logic e_gnt,
      input logic e_mw, input word e_maddr, input logic [3:0] e_mwt, input word e_mwd,
      input logic [1:0] e_rsp, input word e_rdata);
      vec_t r;
      r = '{p_req, p_wr, p_addr, p_wt, p_wd, d_req, d_wr, d_addr, d_wt, d_wd,
            e_stall, e_gnt, e_mw, e_maddr, e_mwt, e_mwd, e_rsp, e_rdata};
      return r;
   endfunction

   task automatic drive(input vec_t x);
      bus.pipe_req      = x.p_req;
      bus.pipe_write    = x.p_wr;
      bus.pipe_addr     = x.p_addr;
      bus.pipe_write_to = x.p_wt;
      bus.pipe_wdata    = x.p_wd;
      bus.dbg_req       = x.d_req;
      bus.dbg_write     = x.d_wr;
      bus.dbg_addr      = x.d_addr;
      bus.dbg_write_to  = x.d_wt;
      bus.dbg_wdata     = x.d_wd;
   endtask

   task automatic chk_rsp(input string tag, input rsp_t r);
      chk({tag, " pipe_rvalid"}, 32'(bus.pipe_rvalid), 32'(r.owner == 2'd1));
      chk({tag, " dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'(r.owner == 2'd2));
      chk({tag, " pipe_rdata"}, bus.pipe_rdata, (r.owner == 2'd1) ? r.data : 32'h0);
      chk({tag, " dbg_rdata"}, bus.dbg_rdata, (r.owner == 2'd2) ? r.data : 32'h0);
   endtask

   initial begin
      vec_t idle;
      rsp_t none;
      idle = '0;
      none = '0;
      drive(idle);

      // Pipeline only: full-word store then load of the same address.
      vecs.push_back(v(1,1,32'h100,4'hF,32'hDEADBEEF, 0,0,0,0,0, 0,0, 1,32'h100,4'hF,32'hDEADBEEF, 0,0));
      vecs.push_back(v(1,0,32'h100,4'h0,0, 0,0,0,0,0, 0,0, 0,32'h100,4'h0,0, 1,32'hDEADBEEF));
      vecs.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0, 0,0));
      vecs.push_back(v(1,1,32'h104,4'hF,32'h12345678, 0,0,0,0,0, 0,0, 1,32'h104,4'hF,32'h12345678, 0,0));
      // Starvation: four pipeline wins, then debug is forced through.
      for (int i = 0; i < 4; i++)
         vecs.push_back(v(1,0,32'h100,0,0, 1,0,32'h100,0,0, 0,0, 0,32'h100,0,0, 1,32'hDEADBEEF));
      vecs.push_back(v(1,0,32'h100,0,0, 1,0,32'h100,0,0, 1,1, 0,32'h100,0,0, 2,32'hDEADBEEF));
      vecs.push_back(v(1,0,32'h100,0,0, 0,0,0,0,0, 0,0, 0,32'h100,0,0, 1,32'hDEADBEEF));
      // Interleaved: pipeline read 0x100 at N, forced debug read 0x104 at N+1.
      for (int i = 0; i < 4; i++)
         vecs.push_back(v(1,0,32'h100,0,0, 1,0,32'h104,0,0, 0,0, 0,32'h100,0,0, 1,32'hDEADBEEF));
      vecs.push_back(v(1,0,32'h100,0,0, 1,0,32'h104,0,0, 1,1, 0,32'h104,0,0, 2,32'h12345678));
      // Debug byte store into lane 1 while the pipeline is idle.
      vecs.push_back(v(0,0,0,0,0, 1,1,32'h101,4'h2,32'h0000AB00, 0,1, 1,32'h101,4'h2,32'h0000AB00, 0,0));
      vecs.push_back(v(1,0,32'h100,0,0, 0,0,0,0,0, 0,0, 0,32'h100,0,0, 1,32'hDEADABEF));
      // Debug abort after two losing cycles; counter must restart from zero.
      for (int i = 0; i < 2; i++)
         vecs.push_back(v(1,0,32'h100,0,0, 1,0,32'h200,0,0, 0,0, 0,32'h100,0,0, 1,32'hDEADABEF));
      vecs.push_back(v(1,0,32'h100,0,0, 0,0,0,0,0, 0,0, 0,32'h100,0,0, 1,32'hDEADABEF));
      for (int i = 0; i < 4; i++)
         vecs.push_back(v(1,0,32'h100,0,0, 1,1,32'h10C,4'hF,32'h55AA55AA, 0,0, 0,32'h100,0,0, 1,32'hDEADABEF));
      vecs.push_back(v(1,0,32'h100,0,0, 1,1,32'h10C,4'hF,32'h55AA55AA, 1,1, 1,32'h10C,4'hF,32'h55AA55AA, 0,0));
      vecs.push_back(v(1,0,32'h10C,0,0, 0,0,0,0,0, 0,0, 0,32'h10C,0,0, 1,32'h55AA55AA));
      vecs.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0, 0,0));

      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset pipe_rvalid", 32'(bus.pipe_rvalid), 32'h0);
      chk("reset dbg_rvalid", 32'(bus.dbg_rvalid), 32'h0);
      chk("reset pipe_rdata", bus.pipe_rdata, 32'h0);
      chk("reset dbg_rdata", bus.dbg_rdata, 32'h0);
      reset = 1'b0;

      // Reset arrives while a pipeline read is granted; its response must vanish.
      @(posedge clock); #1;
      bus.pipe_req  = 1'b1;
      bus.pipe_addr = 32'h100;
      @(negedge clock);
      chk("rst-read pipe_stall", 32'(bus.pipe_stall), 32'h0);
      chk("rst-read mem_addr", bus.mem_addr, 32'h100);
      reset = 1'b1;
      #1 chk("rst-read rvalid in reset", 32'(bus.pipe_rvalid), 32'h0);
      @(posedge clock); #1;
      chk("rst-read rvalid after edge", 32'(bus.pipe_rvalid), 32'h0);
      drive(idle);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("rst-read rvalid after release", 32'(bus.pipe_rvalid), 32'h0);
      chk("rst-read dbg_rvalid after release", 32'(bus.dbg_rvalid), 32'h0);
      @(negedge clock);
      chk("idle mem_write", 32'(bus.mem_write), 32'h0);
      chk("idle mem_addr", bus.mem_addr, 32'h0);
      chk("idle mem_write_to", 32'(bus.mem_write_to), 32'h0);
      chk("idle mem_wdata", bus.mem_wdata, 32'h0);
      chk("idle dbg_gnt", 32'(bus.dbg_gnt), 32'h0);
      @(posedge clock); #1;

      rsp_q.push_back(none);
      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         rsp_t  r;
         tag = $sformatf("row%0d", i);
         drive(vecs[i]);
         @(negedge clock);
         chk({tag, " pipe_stall"}, 32'(bus.pipe_stall), 32'(vecs[i].e_stall));
         chk({tag, " dbg_gnt"}, 32'(bus.dbg_gnt), 32'(vecs[i].e_gnt));
         chk({tag, " mem_write"}, 32'(bus.mem_write), 32'(vecs[i].e_mw));
         chk({tag, " mem_addr"}, bus.mem_addr, vecs[i].e_maddr);
         chk({tag, " mem_write_to"}, 32'(bus.mem_write_to), 32'(vecs[i].e_mwt));
         chk({tag, " mem_wdata"}, bus.mem_wdata, vecs[i].e_mwd);
         r = rsp_q.pop_front();
         chk_rsp(tag, r);
         rsp_q.push_back('{owner: vecs[i].e_rsp, data: vecs[i].e_rdata});
         @(posedge clock); #1;
      end

      drive(idle);
      @(negedge clock);
      while (rsp_q.size() > 0) chk_rsp("drain", rsp_q.pop_front());

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
